// File: rtl/spic_pkg.sv
// Shared constants and types for the SPI controller slice.
package spic_pkg;

  localparam int INSTR_SIZE  = 16;
  localparam int DWIDTH      = 8;
  localparam int NSLAVES     = 4;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spic_rr_pick.sv
// Round-robin picker: the first set request at or after last_grant+1,
// wrapping modulo NREQ.
module spic_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters starting just past the previous winner.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/spic_arbiter.sv
// Arbiter that shares one SPI master between NREQ requesters, one
// transaction at a time, with a completion timeout.
module spic_arbiter
  import spic_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*INSTR_SIZE-1:0] req_instr,
  input  logic [NREQ*2-1:0]          req_cfg,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DWIDTH-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       master_en,
  output logic [INSTR_SIZE-1:0]      driver_data,
  output logic [1:0]                 driver_cfg,
  input  logic                       driver_read,
  input  logic [DWIDTH-1:0]          spi_slv_read_data,
  output logic                       busy
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NREQ - 1);

  arb_state_t             state_q;
  logic [IDX_W-1:0]       winner_q;
  logic [IDX_W-1:0]       last_grant_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NREQ-1:0]        req_ready_q;
  logic [NREQ-1:0]        rsp_valid_q;
  logic [DWIDTH-1:0]      rsp_data_q;
  logic                   rsp_err_q;
  logic                   master_en_q;
  logic [INSTR_SIZE-1:0]  driver_data_q;
  logic [1:0]             driver_cfg_q;
  logic                   busy_q;

  logic [INSTR_SIZE-1:0]  instr_arr [NREQ];
  logic [1:0]             cfg_arr   [NREQ];

  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;
  logic [NREQ-1:0]        pick_onehot;
  logic [NREQ-1:0]        winner_onehot;

  // Split the flat request buses into per-requester words.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign instr_arr[gi] = req_instr[gi*INSTR_SIZE +: INSTR_SIZE];
    assign cfg_arr[gi]   = req_cfg[gi*2 +: 2];
  end

  spic_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .index      (pick_idx)
  );

  assign pick_onehot   = NREQ'(1) << pick_idx;
  assign winner_onehot = NREQ'(1) << winner_q;

  // Transaction FSM: grant, issue to the master, wait for completion or
  // timeout, respond. Every output comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      winner_q      <= '0;
      last_grant_q  <= LAST_INIT;
      cnt_q         <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      master_en_q   <= 1'b0;
      driver_data_q <= '0;
      driver_cfg_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            winner_q      <= pick_idx;
            driver_data_q <= instr_arr[pick_idx];
            driver_cfg_q  <= cfg_arr[pick_idx];
            req_ready_q   <= pick_onehot;
            master_en_q   <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          req_ready_q  <= '0;
          master_en_q  <= 1'b0;
          last_grant_q <= winner_q;
          cnt_q        <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          // A completion in the timeout cycle still counts as success.
          if (driver_read) begin
            rsp_data_q  <= spi_slv_read_data;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= winner_onehot;
            state_q     <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= winner_onehot;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign master_en   = master_en_q;
  assign driver_data = driver_data_q;
  assign driver_cfg  = driver_cfg_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spic_arbiter.sv
// Directed bench for spic_arbiter: reset, single transfer, round-robin,
// timeout, timeout/completion collision, spurious completion, mid-wait reset.
module tb_spic_arbiter;
  import spic_pkg::*;

  localparam int NREQ = 4;
  localparam int TO   = 64;

  logic                       clk;
  logic                       rst_n;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*INSTR_SIZE-1:0] req_instr;
  logic [NREQ*2-1:0]          req_cfg;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0]            rsp_valid;
  logic [DWIDTH-1:0]          rsp_data;
  logic                       rsp_err;
  logic                       master_en;
  logic [INSTR_SIZE-1:0]      driver_data;
  logic [1:0]                 driver_cfg;
  logic                       driver_read;
  logic [DWIDTH-1:0]          spi_slv_read_data;
  logic                       busy;

  int n_checks = 0;
  int n_fail   = 0;

  spic_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_instr         (req_instr),
    .req_cfg           (req_cfg),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_err           (rsp_err),
    .master_en         (master_en),
    .driver_data       (driver_data),
    .driver_cfg        (driver_cfg),
    .driver_read       (driver_read),
    .spi_slv_read_data (spi_slv_read_data),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    rst_n       = 1'b0;
    req_valid   = '0;
    driver_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = '0;
    req_instr = '0;
    req_cfg = '0;
    driver_read = 1'b0;
    spi_slv_read_data = '0;
    tick();
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, master_en, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b rv=%b err=%b en=%b busy=%b expected all 0",
               req_ready, rsp_valid, rsp_err, master_en, busy);
    end
    n_checks++;
    if ({driver_data, driver_cfg, rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got dd=%h dc=%b rd=%h expected 0", driver_data, driver_cfg, rsp_data);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || master_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b en=%b expected 0 0", busy, master_en);
    end
    $display("txn reset: done");
  endtask

  task automatic test_single;
    req_instr[15:0] = 16'h00A5;
    req_cfg[1:0]    = 2'b01;
    req_valid       = 4'b0001;
    tick(); // ISSUE
    n_checks++;
    if (req_ready !== 4'b0001 || master_en !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got rdy=%b en=%b expected 0001 1", req_ready, master_en);
    end
    n_checks++;
    if (driver_data !== 16'h00A5 || driver_cfg !== 2'b01 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_drive: got dd=%h dc=%b busy=%b expected 00a5 01 1",
               driver_data, driver_cfg, busy);
    end
    req_valid   = '0;
    driver_read = 1'b1;  // must be ignored in ISSUE
    spi_slv_read_data = 8'hEE;
    tick(); // WAIT, count 0
    driver_read = 1'b0;
    n_checks++;
    if (req_ready !== 4'b0000 || master_en !== 1'b0 || rsp_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_wait: got rdy=%b en=%b rv=%b expected 0000 0 0000",
               req_ready, master_en, rsp_valid);
    end
    repeat (19) tick();
    driver_read = 1'b1;
    spi_slv_read_data = 8'h3C;
    tick(); // DONE
    n_checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 8'h3C || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: got rv=%b data=%h err=%b expected 0001 3c 0",
               rsp_valid, rsp_data, rsp_err);
    end
    tick(); // IDLE, driver_read still high and ignored in DONE
    driver_read = 1'b0;
    n_checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_data !== 8'h3C || driver_data !== 16'h00A5) begin
      n_fail++;
      $display("FAIL single_hold: got rv=%b busy=%b data=%h dd=%h expected 0000 0 3c 00a5",
               rsp_valid, busy, rsp_data, driver_data);
    end
    $display("txn single: req0 data=%h err=%b", rsp_data, rsp_err);
  endtask

  task automatic test_rr;
    int order [6] = '{0, 1, 2, 3, 0, 2};
    logic [3:0] exp_oh;
    logic [15:0] exp_instr;
    logic [7:0] exp_data;
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      req_instr[k*16 +: 16] = 16'hC000 + 16'(k);
      req_cfg[k*2 +: 2]     = 2'(k);
    end
    req_valid = 4'b1111;
    for (int s = 0; s < 6; s++) begin
      if (s == 4) req_valid = 4'b0101;
      exp_oh    = 4'b0001 << order[s];
      exp_instr = 16'hC000 + 16'(order[s]);
      exp_data  = 8'h10 + 8'(s);
      tick(); // ISSUE
      n_checks++;
      if (req_ready !== exp_oh || master_en !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got rdy=%b en=%b expected %b 1", s, req_ready, master_en, exp_oh);
      end
      n_checks++;
      if (driver_data !== exp_instr || driver_cfg !== 2'(order[s])) begin
        n_fail++;
        $display("FAIL rr_drive%0d: got dd=%h dc=%b expected %h %b",
                 s, driver_data, driver_cfg, exp_instr, 2'(order[s]));
      end
      req_valid[order[s]] = 1'b0;
      tick(); // WAIT
      driver_read = 1'b1;
      spi_slv_read_data = exp_data;
      tick(); // DONE
      driver_read = 1'b0;
      n_checks++;
      if (rsp_valid !== exp_oh || rsp_data !== exp_data || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_rsp%0d: got rv=%b data=%h rdy=%b expected %b %h 0000",
                 s, rsp_valid, rsp_data, req_ready, exp_oh, exp_data);
      end
      tick(); // IDLE gap
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 4'b0000 || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_gap%0d: got busy=%b rv=%b rdy=%b expected 0 0000 0000",
                 s, busy, rsp_valid, req_ready);
      end
      $display("txn rr: step %0d granted req%0d data=%h", s, order[s], rsp_data);
    end
  endtask

  task automatic test_timeout;
    logic early;
    early = 1'b0;
    req_valid = 4'b0010;
    tick(); // ISSUE
    req_valid = '0;
    tick(); // WAIT entry, count 0
    for (int i = 1; i < TO; i++) begin
      tick();
      if (rsp_valid !== 4'b0000) early = 1'b1;
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got early rsp_valid=1 expected none before %0d cycles", TO);
    end
    tick(); // DONE, TO cycles after WAIT entry
    n_checks++;
    if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL timeout_rsp: got rv=%b err=%b data=%h expected 0010 1 00",
               rsp_valid, rsp_err, rsp_data);
    end
    tick();
    $display("txn timeout: req1 err=%b", rsp_err);
  endtask

  task automatic test_same_cycle;
    req_valid = 4'b0100;
    tick(); // ISSUE
    req_valid = '0;
    tick(); // WAIT entry
    repeat (TO - 1) tick(); // count now TO-1
    driver_read = 1'b1;
    spi_slv_read_data = 8'h5A;
    tick(); // DONE
    driver_read = 1'b0;
    n_checks++;
    if (rsp_valid !== 4'b0100 || rsp_err !== 1'b0 || rsp_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL collide_rsp: got rv=%b err=%b data=%h expected 0100 0 5a",
               rsp_valid, rsp_err, rsp_data);
    end
    tick();
    $display("txn collide: req2 data=%h err=%b", rsp_data, rsp_err);
  endtask

  task automatic test_spurious;
    logic bad;
    bad = 1'b0;
    driver_read = 1'b1;
    spi_slv_read_data = 8'hFF;
    repeat (3) begin
      tick();
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) bad = 1'b1;
    end
    driver_read = 1'b0;
    n_checks++;
    if (bad !== 1'b0 || rsp_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL spurious_idle: got bad=%b data=%h expected 0 5a", bad, rsp_data);
    end
    // last grant was 2, so with 0 and 3 pending requester 3 wins
    req_valid = 4'b1001;
    tick();
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL spurious_next: got rdy=%b expected 1000", req_ready);
    end
    req_valid = '0;
    $display("txn spurious: ignored, next grant rdy=%b", req_ready);
  endtask

  task automatic test_reset_mid_wait;
    logic bad;
    bad = 1'b0;
    do_reset();
    req_instr[31:16] = 16'hBEEF;
    req_cfg[3:2]     = 2'b11;
    req_valid = 4'b0010;
    tick(); // ISSUE
    req_valid = '0;
    tick(); // WAIT
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, master_en, busy} !== '0 ||
        {driver_data, driver_cfg, rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: got rdy=%b rv=%b en=%b busy=%b dd=%h dc=%b expected all 0",
               req_ready, rsp_valid, master_en, busy, driver_data, driver_cfg);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < TO + 4; i++) begin
      tick();
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_norsp: got activity after reset expected none");
    end
    req_valid = 4'b1000;
    tick();
    n_checks++;
    if (req_ready !== 4'b1000 || master_en !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_grant: got rdy=%b en=%b expected 1000 1", req_ready, master_en);
    end
    req_valid = '0;
    tick();
    driver_read = 1'b1;
    spi_slv_read_data = 8'h77;
    tick();
    driver_read = 1'b0;
    n_checks++;
    if (rsp_valid !== 4'b1000 || rsp_data !== 8'h77) begin
      n_fail++;
      $display("FAIL midrst_rsp: got rv=%b data=%h expected 1000 77", rsp_valid, rsp_data);
    end
    tick();
    $display("txn midreset: abandoned, req3 data=%h", rsp_data);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_timeout();
    test_same_cycle();
    test_spurious();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
